// File: rtl/ei_axis_rr_stream_mux_if.sv
// Bundled AXI4-Stream ports of ei_axis_rr_stream_mux: NUM_CH packed input channels plus one output stream.
// Modport slave is the mux's own view; modport master is the view of the sources and sink around it.
// m_tid exists only when AXIS_MUX_TID_EN is defined.
interface ei_axis_rr_stream_mux_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int CH_W   = $clog2(NUM_CH);

    logic [NUM_CH-1:0]        s_tvalid;
    logic [NUM_CH-1:0]        s_tready;
    logic [NUM_CH*DATA_W-1:0] s_tdata;
    logic [NUM_CH*KEEP_W-1:0] s_tkeep;
    logic [NUM_CH*KEEP_W-1:0] s_tstrb;
    logic [NUM_CH-1:0]        s_tlast;

    logic                     m_tvalid;
    logic                     m_tready;
    logic [DATA_W-1:0]        m_tdata;
    logic [KEEP_W-1:0]        m_tkeep;
    logic [KEEP_W-1:0]        m_tstrb;
    logic                     m_tlast;

`ifdef AXIS_MUX_TID_EN
    logic [CH_W-1:0]          m_tid;

    modport slave (
        input  s_tvalid, s_tdata, s_tkeep, s_tstrb, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid
    );

    modport master (
        output s_tvalid, s_tdata, s_tkeep, s_tstrb, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid
    );
`else
    modport slave (
        input  s_tvalid, s_tdata, s_tkeep, s_tstrb, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tkeep, m_tstrb, m_tlast
    );

    modport master (
        output s_tvalid, s_tdata, s_tkeep, s_tstrb, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tstrb, m_tlast
    );
`endif

endinterface

// File: rtl/ei_axis_rr_stream_mux.sv
// Round-robin NUM_CH:1 AXI4-Stream mux with packet-granular grant; AXIS_MUX_TID_EN adds m_tid per beat.
// Latency: 2 cycles from s_tvalid in IDLE to m_tvalid (arbitrate + register), then 1 beat/cycle sustained.
// Backpressure: 2-entry output skid; the granted s_tready drops only when both entries are full.
module ei_axis_rr_stream_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    ei_axis_rr_stream_mux_if.slave axis,
    output logic                   busy
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int IW     = CH_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } state_t;

    typedef struct packed {
`ifdef AXIS_MUX_TID_EN
        logic [CH_W-1:0]   tid;
`endif
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic [KEEP_W-1:0] strb;
        logic              last;
    } beat_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [1:0]        cnt_q, cnt_d;
    beat_t             head_q, head_d;
    beat_t             tail_q, tail_d;

    logic              pick_vld;
    logic [CH_W-1:0]   pick_idx;
    logic [NUM_CH-1:0] s_tready_c;
    beat_t             in_beat;
    logic              push;
    logic              pop;

    // First requesting channel at or after the rotating pointer, wrapping modulo NUM_CH.
    always_comb begin
        logic [IW-1:0] sum;
        logic [IW-1:0] idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = IW'(rr_ptr_q) + IW'(i);
            idx = (sum >= IW'(NUM_CH)) ? (sum - IW'(NUM_CH)) : sum;
            if (!pick_vld && axis.s_tvalid[idx[CH_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        in_beat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_q == CH_W'(i)) begin
                in_beat.data = axis.s_tdata[i*DATA_W +: DATA_W];
                in_beat.keep = axis.s_tkeep[i*KEEP_W +: KEEP_W];
                in_beat.strb = axis.s_tstrb[i*KEEP_W +: KEEP_W];
                in_beat.last = axis.s_tlast[i];
            end
        end
`ifdef AXIS_MUX_TID_EN
        in_beat.tid = grant_q;
`endif
    end

    // FSM: state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // FSM: next state. The grant is only released by an accepted TLAST beat.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_PASS;
                    grant_d = pick_idx;
                end
            end
            ST_PASS: begin
                if (push && in_beat.last) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. Ready depends only on registered state, never on m_tready.
    always_comb begin
        s_tready_c = '0;
        if (state_q == ST_PASS && cnt_q != 2'd2) begin
            s_tready_c[grant_q] = 1'b1;
        end
        busy = (state_q == ST_PASS);
    end

    assign push = |(axis.s_tvalid & s_tready_c);
    assign pop  = (cnt_q != 2'd0) && axis.m_tready;

    // Head always feeds the output; tail only fills when the head is stalled.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    head_d = in_beat;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = in_beat;
                end else if (push) begin
                    tail_d = in_beat;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d  = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d = tail_q;
                    cnt_d  = 2'd1;
                end
            end
            default: cnt_d = 2'd0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign axis.s_tready = s_tready_c;
    assign axis.m_tvalid = (cnt_q != 2'd0);
    assign axis.m_tdata  = head_q.data;
    assign axis.m_tkeep  = head_q.keep;
    assign axis.m_tstrb  = head_q.strb;
    assign axis.m_tlast  = head_q.last & (cnt_q != 2'd0);
`ifdef AXIS_MUX_TID_EN
    assign axis.m_tid    = head_q.tid;
`endif

endmodule

// File: tb/tb_ei_axis_rr_stream_mux.sv
// Scoreboard bench for ei_axis_rr_stream_mux: a packet-level round-robin model fills the expected queue,
// a driver process feeds the channels and a monitor process checks every output handshake.
`timescale 1ns/1ps
module tb_ei_axis_rr_stream_mux;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int KEEP_W = DATA_W / 8;
    localparam int CH_W   = 2;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic [KEEP_W-1:0] strb;
        logic              last;
        int                ch;
    } beat_t;

    logic ACLK = 1'b0;
    logic ARESETn;
    logic busy;

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int mptr        = 0;
    int rdy_mode    = 0;
    bit gap_en      = 1'b0;
    int only_ch     = -1;
    int onehot_viol = 0;
    int excl_viol   = 0;

    beat_t src_q[NUM_CH][$];
    beat_t stage_q[NUM_CH][$];
    beat_t exp_q[$];

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    ei_axis_rr_stream_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    ei_axis_rr_stream_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .axis    (bus),
        .busy    (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // mode 0: constant base, 1: incrementing from base, 2: random payload incl. null beats.
    function automatic void add_pkt(input int ch, input int len, input int mode, input logic [31:0] base);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.ch   = ch;
            b.last = (k == len - 1);
            b.data = (mode == 0) ? base : (mode == 1) ? base + k : $urandom;
            b.keep = (mode == 2) ? KEEP_W'($urandom) : '1;
            b.strb = (mode == 2) ? KEEP_W'($urandom) : '1;
            stage_q[ch].push_back(b);
        end
    endfunction

    // Reference: whole packets leave in round-robin order over channels that still hold packets.
    function automatic void launch();
        int    found;
        int    c;
        beat_t b;
        for (int ch = 0; ch < NUM_CH; ch++)
            foreach (stage_q[ch][k]) src_q[ch].push_back(stage_q[ch][k]);
        do begin
            found = -1;
            for (int i = 0; i < NUM_CH; i++) begin
                c = (mptr + i) % NUM_CH;
                if (found < 0 && stage_q[c].size() > 0) found = c;
            end
            if (found >= 0) begin
                do begin
                    b = stage_q[found].pop_front();
                    exp_q.push_back(b);
                end while (!b.last);
                mptr = (found + 1) % NUM_CH;
            end
        end while (found >= 0);
    endfunction

    function automatic bit src_pending();
        bit r = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) if (src_q[ch].size() > 0) r = 1'b1;
        return r;
    endfunction

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || src_pending()) && n < budget) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || src_pending()) begin
            errors++;
            $display("FAIL %s: %0d beats still expected after %0d cycles, required 0", name, exp_q.size(), budget);
        end
    endtask

    task automatic wait_exp_le(input int lim, input int budget, input string name);
        int n = 0;
        while (exp_q.size() > lim && n < budget) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (exp_q.size() > lim) begin
            errors++;
            $display("FAIL %s: %0d beats pending, required <= %0d", name, exp_q.size(), lim);
        end
    endtask

    // Driver: presents the head beat of each channel; gaps only inside a packet.
    initial begin : driver
        logic [NUM_CH-1:0] acc;
        logic [NUM_CH-1:0] vld;
        logic [NUM_CH-1:0] in_pkt;
        bit                alt;
        beat_t             b;
        vld          = '0;
        in_pkt       = '0;
        alt          = 1'b0;
        bus.s_tvalid = '0;
        bus.s_tdata  = '0;
        bus.s_tkeep  = '0;
        bus.s_tstrb  = '0;
        bus.s_tlast  = '0;
        bus.m_tready = 1'b0;
        forever begin
            @(negedge ACLK);
            acc = bus.s_tvalid & bus.s_tready;
            @(posedge ACLK);
            #1;
            alt = !alt;
            case (rdy_mode)
                0:       bus.m_tready = 1'b1;
                1:       bus.m_tready = alt;
                default: bus.m_tready = ($urandom_range(0, 1) == 1);
            endcase
            for (int i = 0; i < NUM_CH; i++) begin
                if (ARESETn !== 1'b1) begin
                    vld[i]    = 1'b0;
                    in_pkt[i] = 1'b0;
                end else begin
                    if (acc[i] && src_q[i].size() > 0) begin
                        b         = src_q[i].pop_front();
                        in_pkt[i] = !b.last;
                    end
                    if (src_q[i].size() == 0)        vld[i] = 1'b0;
                    else if (vld[i] && !acc[i])      vld[i] = 1'b1;
                    else if (!in_pkt[i] || !gap_en) vld[i] = 1'b1;
                    else                             vld[i] = ($urandom_range(0, 3) != 0);
                    if (src_q[i].size() > 0) begin
                        b = src_q[i][0];
                        bus.s_tdata[i*DATA_W +: DATA_W] = b.data;
                        bus.s_tkeep[i*KEEP_W +: KEEP_W] = b.keep;
                        bus.s_tstrb[i*KEEP_W +: KEEP_W] = b.strb;
                        bus.s_tlast[i]                  = b.last;
                    end
                end
            end
            bus.s_tvalid = vld;
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks hold-while-stalled.
    initial begin : monitor
        beat_t                     e;
        logic                      stall;
        logic [NUM_CH-1:0]         allow;
        logic [DATA_W+2*KEEP_W:0]  pay;
        logic [DATA_W+2*KEEP_W:0]  prev_pay;
        logic [DATA_W+2*KEEP_W:0]  exp_pay;
        stall    = 1'b0;
        prev_pay = '0;
        forever begin
            @(negedge ACLK);
            pay = {bus.m_tdata, bus.m_tkeep, bus.m_tstrb, bus.m_tlast};
            if (ARESETn !== 1'b1) begin
                stall = 1'b0;
            end else begin
                if ($countones(bus.s_tready) > 1 || (bus.s_tready != '0 && !busy)) onehot_viol++;
                if (only_ch >= 0) begin
                    allow          = '0;
                    allow[only_ch] = 1'b1;
                    if ((bus.s_tready & ~allow) != '0) excl_viol++;
                end
                if (stall) begin
                    checks++;
                    if (bus.m_tvalid !== 1'b1 || pay !== prev_pay) begin
                        errors++;
                        $display("FAIL hold: valid=%0b payload=%h, required valid=1 payload=%h",
                                 bus.m_tvalid, pay, prev_pay);
                    end
                end
                if (bus.m_tvalid === 1'b1 && bus.m_tready === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat: unexpected data=%h, required no beat", bus.m_tdata);
                    end else begin
                        e       = exp_q.pop_front();
                        exp_pay = {e.data, e.keep, e.strb, e.last};
`ifdef AXIS_MUX_TID_EN
                        if (pay !== exp_pay || bus.m_tid !== CH_W'(e.ch)) begin
                            errors++;
                            $display("FAIL beat: got payload=%h tid=%0d, required payload=%h tid=%0d",
                                     pay, bus.m_tid, exp_pay, e.ch);
                        end
`else
                        if (pay !== exp_pay) begin
                            errors++;
                            $display("FAIL beat: got payload=%h, required payload=%h (ch%0d)",
                                     pay, exp_pay, e.ch);
                        end
`endif
                    end
                end
                stall    = bus.m_tvalid && !bus.m_tready;
                prev_pay = pay;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int t0;
        int t1;
        int n;
        ARESETn = 1'b1;
        #2 ARESETn = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("rst_m_tvalid", 32'(bus.m_tvalid), 0);
        chk("rst_s_tready", 32'(bus.s_tready), 0);
        chk("rst_busy",     32'(busy), 0);
        chk("rst_m_tlast",  32'(bus.m_tlast), 0);
        chk("rst_m_tdata",  bus.m_tdata, 0);
        ARESETn = 1'b1;
        @(negedge ACLK);

        // Single 3-beat packet on ch2: latency and exclusive ready.
        only_ch = 2;
        add_pkt(2, 3, 1, 32'hA0);
        launch();
        t0 = -1;
        t1 = -1;
        n  = 0;
        while (t1 < 0 && n < 50) begin
            @(negedge ACLK);
            if (t0 < 0 && bus.s_tvalid[2]) t0 = cyc;
            if (bus.m_tvalid) t1 = cyc;
            n++;
        end
        chk("latency", 32'(t1 - t0), 2);
        wait_drain(100, "t1_drain");
        only_ch = -1;

        // Reset in the middle of a 4-beat packet on ch3.
        add_pkt(3, 4, 1, 32'h30);
        launch();
        wait_exp_le(3, 50, "t5_start");
        #2 ARESETn = 1'b0;
        #1;
        chk("mid_rst_m_tvalid", 32'(bus.m_tvalid), 0);
        chk("mid_rst_s_tready", 32'(bus.s_tready), 0);
        chk("mid_rst_m_tlast",  32'(bus.m_tlast), 0);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            src_q[ch].delete();
            stage_q[ch].delete();
        end
        exp_q.delete();
        mptr = 0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);

        // Four-way tie of 1-beat packets, data = channel index: 0,1,2,3,0,1.
        for (int ch = 0; ch < NUM_CH; ch++) add_pkt(ch, 1, 0, 32'(ch));
        add_pkt(0, 1, 0, 32'd0);
        add_pkt(1, 1, 0, 32'd1);
        launch();
        wait_drain(200, "t2_drain");

        // 8-beat incrementing packet with alternating m_tready.
        rdy_mode = 1;
        add_pkt(0, 8, 1, 32'h10);
        launch();
        wait_drain(200, "t3_drain");
        rdy_mode = 0;

        // ch0 requests while ch1 holds the grant.
        only_ch = 1;
        add_pkt(1, 5, 1, 32'h50);
        launch();
        wait_exp_le(3, 50, "t4_mid");
        add_pkt(0, 2, 1, 32'h60);
        launch();
        n = 0;
        while (src_q[1].size() > 0 && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        only_ch = -1;
        wait_drain(200, "t4_drain");

        // Randomized batches with source gaps and random backpressure.
        gap_en   = 1'b1;
        rdy_mode = 2;
        for (int bt = 0; bt < 25; bt++) begin
            int np = 0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                int k = $urandom_range(0, 2);
                for (int p = 0; p < k; p++) begin
                    add_pkt(ch, $urandom_range(1, 6), 2, 32'h0);
                    np++;
                end
            end
            if (np == 0) add_pkt($urandom_range(0, NUM_CH - 1), $urandom_range(1, 6), 2, 32'h0);
            launch();
            wait_drain(2000, "rand_drain");
        end

        repeat (4) @(negedge ACLK);
        chk("exp_empty",     32'(exp_q.size()), 0);
        chk("sready_onehot", 32'(onehot_viol), 0);
        chk("sready_excl",   32'(excl_viol), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
